bus_master_port: RTL and testbench
==================================

# bus_master_port

Bit-serial bus master port: accepts parallel read/write requests from a local device over a valid/ready interface and serialises them onto a one-bit system bus. The `slave` counterpart owns a 4096×8 memory indexed by address bits [11:0]. Writes shift address and data out to the slave. Reads shift the address out, then shift the slave's returned data back in and present it in parallel. The block sits between a device (CPU/DMA) and the serial bus/arbiter.

## Interface
- ADDR_WIDTH, 16, device address width; all bits serialised.
- DATA_WIDTH, 8, data word width.
- clk  in  1  single clock; all state changes on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- dwdata  in  DATA_WIDTH  device write data.
- drdata  out  DATA_WIDTH  read result; valid while dready=1 after a read.
- daddr  in  ADDR_WIDTH  request address.
- dvalid  in  1  request valid.
- dready  out  1  port idle and able to accept a request.
- dmode  in  1  0=read, 1=write.
- mrdata  in  1  serial read data from the slave.
- mwdata  out  1  serial address/write data to the slave.
- mmode  out  1  mode of the current transfer: 0=read, 1=write.
- mvalid  out  1  mwdata bit valid.
- svalid  in  1  mrdata bit valid.

## Operation
- States: IDLE, ADDR, WDATA, RWAIT/RDATA.
- IDLE: dready=1, mvalid=0. A request is accepted on a rising edge where dvalid & dready. On acceptance:
  - latch daddr, dwdata and dmode;
  - set mmode to the latched dmode;
  - go to ADDR.
- ADDR: drive the address LSB first, one bit per cycle with mvalid=1, for ADDR_WIDTH cycles. Next state is WDATA if the request is a write, RWAIT if a read.
- WDATA: drive dwdata LSB first for DATA_WIDTH cycles with mvalid=1, then return to IDLE.
- RWAIT/RDATA: mvalid=0. On each edge with svalid=1, shift mrdata in, LSB first. After DATA_WIDTH bits, load drdata and return to IDLE.
- dvalid is ignored while dready=0. A request held high across several cycles is accepted once only.
- mmode holds its value for the whole transfer.
- Slave behaviour:
  - samples mwdata on edges where mvalid=1;
  - uses address bits [11:0] and ignores the upper bits;
  - on a write, commits memory on the edge that samples the last data bit;
  - on a read, raises svalid on the cycle after the last address bit and streams memory[addr] LSB first for DATA_WIDTH cycles.

## Timing
- Reset values: dready=1, drdata=0, mwdata=0, mmode=0, mvalid=0, state IDLE. The slave's memory is not reset.
- Let E0 be the acceptance edge.
  - Write: bit i (0 to ADDR_WIDTH+DATA_WIDTH-1) is on mwdata between E_i and E_(i+1). mvalid falls and dready rises at E_(ADDR_WIDTH+DATA_WIDTH), i.e. E24 at default widths. Slave memory is updated at E24.
  - Read: the last address bit is driven between E15 and E16. The slave streams during E16–E24. drdata loads and dready rises at E24 (E25 at the latest).
- Reset asserted mid-transfer aborts immediately to the reset values. The slave discards any partial transfer.

## Configuration
- MASTER_PORT_TIMEOUT_EN:
  - Defined: a 6-bit counter runs in RWAIT. If svalid has not arrived after 63 cycles, the port returns to IDLE with drdata=0.
  - Undefined: the port waits for svalid indefinitely.

## Structure
- Shared package `bus_pkg`:
  - state enum;
  - MODE_READ=0 and MODE_WRITE=1;
  - default widths;
  - slave memory depth of 4096 (12-bit index).
- One natural sub-module, `slave_mem` (instance `sm`, array `memory`): 4096×8 synchronous-write storage used inside `slave`.
- master_port holds a shift register and a bit counter.

## Test plan
- Reset: hold rstn=0 for 15 ns -> dready=1, mvalid=0, drdata=0.
- Write: daddr=0x0524, dwdata=0x81, dmode=1, dvalid high for 2 cycles -> dready low for exactly 24 cycles, then memory[0x524]=0x81.
- Read back: daddr=0x0524, dmode=0 -> after dready rises, drdata=0x81 and mmode was 0 throughout.
- Upper address bits ignored: write 0x5A to daddr=0xF123, read daddr=0x0123 -> drdata=0x5A.
- Reset mid-transfer: drop rstn at E10 of a write -> outputs return to reset values and memory is unchanged.
- Timeout, with MASTER_PORT_TIMEOUT_EN defined and the slave replaced by a stub that never asserts svalid: read -> dready returns at E79 (16 + 63), drdata=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial bus: master FSM states, transfer modes,
// default widths and the slave memory geometry.
package bus_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int MEM_DEPTH  = 4096;
    localparam int MEM_IDX_W  = 12;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WDATA = 2'd2,
        ST_RWAIT = 2'd3
    } state_t;
endpackage

// File: rtl/slave.sv
// Serial bus slave: collects address (and write data) LSB first, writes memory on
// the last data bit, or streams memory[addr] back the cycle after the last address bit.
module slave
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic mwdata,
    input  logic mmode,
    input  logic mvalid,
    output logic mrdata,
    output logic svalid
);
    localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_A = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] LAST_W = CW'(ADDR_WIDTH + DATA_WIDTH - 1);
    localparam logic [CW-1:0] IDX_W  = CW'(MEM_IDX_W);
    localparam logic [IW-1:0] LAST_D = IW'(DATA_WIDTH - 1);

    logic [CW-1:0]         cnt;
    logic [MEM_IDX_W-1:0]  ash;
    logic [DATA_WIDTH-2:0] dsh;
    logic                  stream;
    logic [IW-1:0]         idx;
    logic                  we;
    logic [7:0]            rdata;

    // Only the low address bits are captured; the upper bits just advance the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            ash    <= '0;
            dsh    <= '0;
            stream <= 1'b0;
            idx    <= '0;
        end else begin
            if (stream) begin
                idx <= idx + 1'b1;
                if (idx == LAST_D) stream <= 1'b0;
            end
            if (mvalid) begin
                if (cnt < IDX_W) ash <= {mwdata, ash[MEM_IDX_W-1:1]};
                if (cnt > LAST_A) dsh <= {mwdata, dsh[DATA_WIDTH-2:1]};
                if ((cnt == LAST_A && mmode == MODE_READ) || cnt == LAST_W) begin
                    cnt <= '0;
                    if (mmode == MODE_READ) begin
                        stream <= 1'b1;
                        idx    <= '0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign we     = mvalid && (mmode == MODE_WRITE) && (cnt == LAST_W);
    assign svalid = stream;
    assign mrdata = stream & rdata[idx];

    slave_mem sm (
        .clk   (clk),
        .we    (we),
        .addr  (ash),
        .wdata ({mwdata, dsh}),
        .rdata (rdata)
    );
endmodule

// File: rtl/slave_mem.sv
// 4096x8 storage for the serial slave: synchronous write, combinational read.
// Contents are deliberately not reset.
module slave_mem
    import bus_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [MEM_IDX_W-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);
    logic [7:0] memory [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
    end

    assign rdata = memory[addr];
endmodule

// File: rtl/bus_master_port.sv
// Bit-serial bus master: accepts one parallel request while idle, shifts address/data
// out LSB first, shifts read data back in. MASTER_PORT_TIMEOUT_EN adds a read timeout.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic                  dvalid,
    output logic                  dready,
    input  logic                  dmode,
    input  logic                  mrdata,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  svalid
);
    localparam int TW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(TW);
    localparam logic [CW-1:0] LAST_A = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] LAST_D = CW'(DATA_WIDTH - 1);

    state_t        state;
    logic [TW-1:0] sreg;
    logic [CW-1:0] cnt;
`ifdef MASTER_PORT_TIMEOUT_EN
    logic [5:0]    tcnt;
`endif

    // One shift register serves both directions: out from bit 0, read data in at the top.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            cnt    <= '0;
            mmode  <= MODE_READ;
            drdata <= '0;
`ifdef MASTER_PORT_TIMEOUT_EN
            tcnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dvalid) begin
                        sreg  <= {dwdata, daddr};
                        mmode <= dmode;
                        cnt   <= '0;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    sreg <= sreg >> 1;
                    if (cnt == LAST_A) begin
                        cnt   <= '0;
                        state <= (mmode == MODE_WRITE) ? ST_WDATA : ST_RWAIT;
`ifdef MASTER_PORT_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WDATA: begin
                    sreg <= sreg >> 1;
                    if (cnt == LAST_D) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RWAIT: begin
                    if (svalid) begin
                        sreg <= {mrdata, sreg[TW-1:1]};
                        if (cnt == LAST_D) begin
                            drdata <= {mrdata, sreg[TW-1:TW-DATA_WIDTH+1]};
                            cnt    <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef MASTER_PORT_TIMEOUT_EN
                    // Give up after 63 silent cycles, only if no data bit has arrived.
                    else if (cnt == '0) begin
                        if (tcnt == 6'd62) begin
                            drdata <= '0;
                            state  <= ST_IDLE;
                        end
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dready = (state == ST_IDLE);
    assign mvalid = (state == ST_ADDR) || (state == ST_WDATA);
    assign mwdata = mvalid & sreg[0];
endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port with the serial slave attached; the timeout
// case runs only when MASTER_PORT_TIMEOUT_EN is defined.
module tb_bus_master_port;
    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  dwdata;
    logic [7:0]  drdata;
    logic [15:0] daddr;
    logic        dvalid;
    logic        dready;
    logic        dmode;
    logic        mrdata;
    logic        mwdata;
    logic        mmode;
    logic        mvalid;
    logic        sv_slave;
    logic        sv_port;
    logic        stub = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sv_port = stub ? 1'b0 : sv_slave;

    bus_master_port dut (
        .clk    (clk),
        .rstn   (rstn),
        .dwdata (dwdata),
        .drdata (drdata),
        .daddr  (daddr),
        .dvalid (dvalid),
        .dready (dready),
        .dmode  (dmode),
        .mrdata (mrdata),
        .mwdata (mwdata),
        .mmode  (mmode),
        .mvalid (mvalid),
        .svalid (sv_port)
    );

    slave u_slave (
        .clk    (clk),
        .rstn   (rstn),
        .mwdata (mwdata),
        .mmode  (mmode),
        .mvalid (mvalid),
        .mrdata (mrdata),
        .svalid (sv_slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request (called #1 after an edge) and sample until dready returns.
    task automatic transfer(input logic mode, input logic [15:0] addr, input logic [7:0] data,
                            input int hold, output int n, output int mv,
                            output logic [23:0] bits, output int mode_bad);
        n = 0;
        mv = 0;
        bits = '0;
        mode_bad = 0;
        daddr  = addr;
        dwdata = data;
        dmode  = mode;
        dvalid = 1'b1;
        @(posedge clk);
        #1;
        while (!dready && n < 200) begin
            if (n >= hold - 1) dvalid = 1'b0;
            if (mvalid) begin
                mv++;
                if (n < 24) bits[n] = mwdata;
            end
            if (mmode !== mode) mode_bad++;
            n++;
            @(posedge clk);
            #1;
        end
        dvalid = 1'b0;
    endtask

    int          n;
    int          mv;
    int          mbad;
    logic [23:0] bits;

    initial begin
        rstn   = 1'b0;
        dvalid = 1'b0;
        dwdata = '0;
        daddr  = '0;
        dmode  = 1'b0;
        #2;
        #12;
        check("rst_dready", dready, 1);
        check("rst_mvalid", mvalid, 0);
        check("rst_drdata", drdata, 0);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        transfer(1'b1, 16'h0524, 8'h81, 2, n, mv, bits, mbad);
        check("wr_busy_cycles", n, 24);
        check("wr_mvalid_cycles", mv, 24);
        check("wr_serial_bits", bits, 24'h810524);
        check("wr_mmode_held", mbad, 0);
        check("wr_mem_524", u_slave.sm.memory[12'h524], 8'h81);
        check("wr_idle_mvalid", mvalid, 0);

        transfer(1'b0, 16'h0524, 8'h00, 1, n, mv, bits, mbad);
        check("rd_busy_cycles", n, 24);
        check("rd_mvalid_cycles", mv, 16);
        check("rd_addr_bits", bits[15:0], 16'h0524);
        check("rd_mmode_low", mbad, 0);
        check("rd_drdata", drdata, 8'h81);

        transfer(1'b1, 16'hF123, 8'h5A, 1, n, mv, bits, mbad);
        check("wr_hi_busy_cycles", n, 24);
        check("wr_hi_mem_123", u_slave.sm.memory[12'h123], 8'h5A);
        transfer(1'b0, 16'h0123, 8'h00, 1, n, mv, bits, mbad);
        check("rd_alias_drdata", drdata, 8'h5A);

        daddr  = 16'h0524;
        dwdata = 8'h3C;
        dmode  = 1'b1;
        dvalid = 1'b1;
        @(posedge clk);
        #1 dvalid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("abort_dready", dready, 1);
        check("abort_mvalid", mvalid, 0);
        check("abort_mwdata", mwdata, 0);
        check("abort_mmode", mmode, 0);
        check("abort_drdata", drdata, 0);
        check("abort_mem_524", u_slave.sm.memory[12'h524], 8'h81);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        transfer(1'b0, 16'h0524, 8'h00, 1, n, mv, bits, mbad);
        check("post_abort_busy", n, 24);
        check("post_abort_drdata", drdata, 8'h81);

`ifdef MASTER_PORT_TIMEOUT_EN
        stub = 1'b1;
        transfer(1'b0, 16'h0524, 8'h00, 1, n, mv, bits, mbad);
        check("timeout_busy_cycles", n, 79);
        check("timeout_drdata", drdata, 0);
        stub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
